// File: rtl/payload_word_packer.sv
// Packs an unbackpressured byte stream into WORD_BYTES-wide words and queues them (FWFT, valid/ready out).
// Optional statistics counters are enabled by defining PACKER_STATS_EN.
module payload_word_packer #(
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned BIG_ENDIAN  = 0,
  parameter int unsigned PAD_PARTIAL = 1,
  parameter int unsigned FILTER_ZERO = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic [8*WORD_BYTES-1:0]   m_data,
  output logic                      m_last,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [$clog2(DEPTH):0]    fifo_level,
  output logic                      overflow_sticky,
  input  logic                      overflow_clr
`ifdef PACKER_STATS_EN
  ,
  output logic [15:0]               pkt_cnt,
  output logic [15:0]               word_cnt,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int unsigned W  = 8 * WORD_BYTES;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [IW-1:0] LAST_LANE = IW'(WORD_BYTES - 1);

  typedef enum logic {ASSEMBLE, DISCARD} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  asm_q, asm_d;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic [AW:0]   rd_cnt_q, rd_cnt_d;
  logic          ovf_q, ovf_d;
  logic [W-1:0]  mem_data_q [DEPTH];
  logic          mem_last_q [DEPTH];

  logic [AW:0]   level;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          overflow;
  logic [IW-1:0] lane;
  logic [W-1:0]  word;

  assign level = wr_cnt_q - rd_cnt_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign pop   = m_valid && m_ready;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    asm_d    = asm_q;
    ovf_d    = overflow_clr ? 1'b0 : ovf_q;
    push     = 1'b0;
    drop     = 1'b0;
    overflow = 1'b0;
    lane     = (BIG_ENDIAN != 0) ? (LAST_LANE - idx_q) : idx_q;
    word     = asm_q;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (lane == IW'(i)) word[8*i +: 8] = s_axis_tdata;
    end

    if (s_axis_tvalid) begin
      unique case (state_q)
        ASSEMBLE: begin
          if (idx_q == LAST_LANE || s_axis_tlast) begin
            idx_d = '0;
            asm_d = '0;
            // Priority: partial-drop, then zero filter, then full queue.
            if (idx_q != LAST_LANE && PAD_PARTIAL == 0) begin
              drop = 1'b1;
            end else if (FILTER_ZERO != 0 && word == '0) begin
              drop = 1'b1;
            end else if (full) begin
              overflow = 1'b1;
              ovf_d    = 1'b1;
              if (!s_axis_tlast) state_d = DISCARD;
            end else begin
              push = 1'b1;
            end
          end else begin
            idx_d = idx_q + IW'(1);
            asm_d = word;
          end
        end
        DISCARD: begin
          if (s_axis_tlast) state_d = ASSEMBLE;
        end
        default: state_d = ASSEMBLE;
      endcase
    end

    wr_cnt_d = wr_cnt_q + {{AW{1'b0}}, push};
    rd_cnt_d = rd_cnt_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ASSEMBLE;
      idx_q    <= '0;
      asm_q    <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      asm_q    <= asm_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_cnt_q[AW-1:0]] <= word;
      mem_last_q[wr_cnt_q[AW-1:0]] <= s_axis_tlast;
    end
  end

  // Outputs are gated by occupancy so an empty queue presents zeros.
  assign m_valid         = (level != '0);
  assign m_data          = m_valid ? mem_data_q[rd_cnt_q[AW-1:0]] : '0;
  assign m_last          = m_valid ? mem_last_q[rd_cnt_q[AW-1:0]] : 1'b0;
  assign fifo_level      = level;
  assign overflow_sticky = ovf_q;

`ifdef PACKER_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    pkt_cnt_d  = pkt_cnt_q + {15'd0, s_axis_tvalid && s_axis_tlast};
    word_cnt_d = word_cnt_q + {15'd0, push};
    drop_cnt_d = drop_cnt_q + {15'd0, drop || overflow};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q  <= '0;
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt  = pkt_cnt_q;
  assign word_cnt = word_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_payload_word_packer.sv
// Directed bench for payload_word_packer: four parameterisations driven from one shared byte stream.
module tb_payload_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        m_ready = 1'b0;
  logic        overflow_clr = 1'b0;

  logic [31:0] md  [4];
  logic        ml  [4];
  logic        mv  [4];
  logic        ovf [4];
  logic [4:0]  lvl_a, lvl_b, lvl_c;
  logic [2:0]  lvl_d;

  int checks = 0;
  int failures = 0;
  int stab_err = 0;

  typedef struct packed {
    int          dut;
    logic [31:0] d;
    logic        l;
  } cap_t;
  cap_t cap[$];

  logic        hold_q [4];
  logic [31:0] hold_d [4];

  always #5 clk = ~clk;

  payload_word_packer #(.WORD_BYTES(4), .DEPTH(16), .BIG_ENDIAN(0), .PAD_PARTIAL(1), .FILTER_ZERO(1)) dut_a (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .m_data(md[0]), .m_last(ml[0]), .m_valid(mv[0]), .m_ready(m_ready),
    .fifo_level(lvl_a), .overflow_sticky(ovf[0]), .overflow_clr(overflow_clr));

  payload_word_packer #(.WORD_BYTES(4), .DEPTH(16), .BIG_ENDIAN(1), .PAD_PARTIAL(1), .FILTER_ZERO(1)) dut_b (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .m_data(md[1]), .m_last(ml[1]), .m_valid(mv[1]), .m_ready(m_ready),
    .fifo_level(lvl_b), .overflow_sticky(ovf[1]), .overflow_clr(overflow_clr));

  payload_word_packer #(.WORD_BYTES(4), .DEPTH(16), .BIG_ENDIAN(0), .PAD_PARTIAL(0), .FILTER_ZERO(1)) dut_c (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .m_data(md[2]), .m_last(ml[2]), .m_valid(mv[2]), .m_ready(m_ready),
    .fifo_level(lvl_c), .overflow_sticky(ovf[2]), .overflow_clr(overflow_clr));

  payload_word_packer #(.WORD_BYTES(4), .DEPTH(4), .BIG_ENDIAN(0), .PAD_PARTIAL(1), .FILTER_ZERO(1)) dut_d (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tlast(tlast),
    .m_data(md[3]), .m_last(ml[3]), .m_valid(mv[3]), .m_ready(m_ready),
    .fifo_level(lvl_d), .overflow_sticky(ovf[3]), .overflow_clr(overflow_clr));

  // Record every handshake and flag any head change while stalled.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rst) begin
        hold_q[k] = 1'b0;
      end else begin
        if (mv[k] && m_ready) begin
          cap_t e;
          e.dut = k;
          e.d   = md[k];
          e.l   = ml[k];
          cap.push_back(e);
        end
        if (hold_q[k] && md[k] !== hold_d[k]) stab_err++;
        hold_q[k] = mv[k] && !m_ready;
        hold_d[k] = md[k];
      end
    end
  end

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    tdata  = d;
    tvalid = 1'b1;
    tlast  = l;
    @(posedge clk);
    #1;
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  function automatic int cnt(input int k);
    int n = 0;
    foreach (cap[i]) if (cap[i].dut == k) n++;
    return n;
  endfunction

  task automatic chk_word(input int k, input int n, input logic [31:0] d, input logic l, input string tag);
    logic [31:0] od = 'x;
    logic        ol = 1'bx;
    int          seen = 0;
    foreach (cap[i]) begin
      if (cap[i].dut == k) begin
        if (seen == n) begin
          od = cap[i].d;
          ol = cap[i].l;
        end
        seen++;
      end
    end
    chk({32'd0, od}, {32'd0, d}, tag);
    chk({63'd0, ol}, {63'd0, l}, {tag, "_last"});
  endtask

  logic [7:0]  pkt [22];
  logic [31:0] exp_d[$];
  logic        exp_l[$];

  initial begin
    // Reset state
    idle(3);
    rst = 1'b0;
    chk({63'd0, mv[0]}, 64'd0, "rst_valid");
    chk({32'd0, md[0]}, 64'd0, "rst_data");
    chk({63'd0, ml[0]}, 64'd0, "rst_last");
    chk({59'd0, lvl_a}, 64'd0, "rst_level");
    chk({63'd0, ovf[0]}, 64'd0, "rst_ovf");

    // Ordering, latency and byte order
    m_ready = 1'b1;
    cap.delete();
    send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
    chk({63'd0, mv[0]}, 64'd0, "lat_before");
    send(8'h04, 0);
    chk({63'd0, mv[0]}, 64'd1, "lat_valid");
    chk({32'd0, md[0]}, 64'h04030201, "lat_data");
    send(8'h05, 0); send(8'h06, 0); send(8'h07, 0); send(8'h08, 1);
    idle(4);
    chk(64'(cnt(0)), 64'd2, "order_cnt");
    chk_word(0, 0, 32'h04030201, 1'b0, "order_w0");
    chk_word(0, 1, 32'h08070605, 1'b1, "order_w1");
    chk_word(1, 0, 32'h01020304, 1'b0, "be_w0");
    chk_word(1, 1, 32'h05060708, 1'b1, "be_w1");

    // Partial tails
    cap.delete();
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 0); send(8'hEE, 0); send(8'hFF, 1);
    idle(4);
    chk(64'(cnt(0)), 64'd2, "pad_cnt");
    chk_word(0, 0, 32'hDDCCBBAA, 1'b0, "pad_w0");
    chk_word(0, 1, 32'h0000FFEE, 1'b1, "pad_w1");
    chk_word(1, 1, 32'hEEFF0000, 1'b1, "pad_be_w1");
    chk(64'(cnt(2)), 64'd1, "nopad_cnt");
    chk_word(2, 0, 32'hDDCCBBAA, 1'b0, "nopad_w0");

    // Zero filter
    cap.delete();
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    send(8'h11, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 1);
    idle(4);
    chk(64'(cnt(0)), 64'd1, "zf_cnt");
    chk_word(0, 0, 32'h00000011, 1'b1, "zf_w0");

    // Overflow on the DEPTH=4 instance
    m_ready = 1'b0;
    cap.delete();
    for (int i = 1; i <= 24; i++) send(8'(i), i == 24);
    idle(2);
    chk({61'd0, lvl_d}, 64'd4, "ovf_level");
    chk({63'd0, ovf[3]}, 64'd1, "ovf_sticky");
    chk({59'd0, lvl_a}, 64'd6, "deep_level");
    chk({63'd0, ovf[0]}, 64'd0, "deep_no_ovf");
    m_ready = 1'b1;
    idle(8);
    chk(64'(cnt(3)), 64'd4, "ovf_drain_cnt");
    chk_word(3, 0, 32'h04030201, 1'b0, "ovf_w0");
    chk_word(3, 3, 32'h100F0E0D, 1'b0, "ovf_w3");
    chk({61'd0, lvl_d}, 64'd0, "ovf_drained");
    cap.delete();
    for (int i = 0; i < 8; i++) send(8'(8'h21 + i), i == 7);
    idle(4);
    chk(64'(cnt(3)), 64'd2, "post_ovf_cnt");
    chk_word(3, 1, 32'h28272625, 1'b1, "post_ovf_w1");
    chk({63'd0, ovf[3]}, 64'd1, "sticky_held");
    overflow_clr = 1'b1;
    idle(1);
    overflow_clr = 1'b0;
    chk({63'd0, ovf[3]}, 64'd0, "sticky_clr");

    // Random m_ready against a reference packing model
    cap.delete();
    exp_d.delete();
    exp_l.delete();
    begin
      logic [31:0] w = '0;
      int idx = 0;
      for (int i = 0; i < 22; i++) begin
        pkt[i] = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
        w[8*idx +: 8] = pkt[i];
        if (idx == 3 || i == 21) begin
          if (w != '0) begin
            exp_d.push_back(w);
            exp_l.push_back(i == 21);
          end
          w = '0;
          idx = 0;
        end else begin
          idx++;
        end
      end
    end
    for (int i = 0; i < 22; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      send(pkt[i], i == 21);
    end
    m_ready = 1'b1;
    idle(20);
    chk(64'(cnt(0)), 64'(exp_d.size()), "hs_cnt");
    foreach (exp_d[i]) chk_word(0, i, exp_d[i], exp_l[i], $sformatf("hs_w%0d", i));
    chk(64'(stab_err), 64'd0, "hs_stable");

    // Reset mid-packet
    m_ready = 1'b0;
    cap.delete();
    for (int i = 0; i < 14; i++) send(8'(8'h41 + i), 1'b0);
    chk({59'd0, lvl_a}, 64'd3, "mid_level");
    rst = 1'b1;
    #2;
    chk({63'd0, mv[0]}, 64'd0, "mid_rst_valid");
    chk({59'd0, lvl_a}, 64'd0, "mid_rst_level");
    idle(1);
    rst = 1'b0;
    m_ready = 1'b1;
    send(8'h31, 0); send(8'h32, 0); send(8'h33, 0); send(8'h34, 1);
    idle(3);
    chk(64'(cnt(0)), 64'd1, "post_rst_cnt");
    chk_word(0, 0, 32'h34333231, 1'b1, "post_rst_w0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
